// File: rtl/keypad_osd_pkg.sv
// Shared constants and types for the keypad OSD stages: key grid geometry,
// cell origins and the highlight state encoding.
package keypad_osd_pkg;

   localparam int NUM_KEYS   = 12;
   localparam int NUM_COLS   = 3;
   localparam int NUM_ROWS   = 4;
   localparam int DIGIT_W    = 16;
   localparam int DIGIT_H    = 32;
   localparam int BOX_MARGIN = 8;
   localparam int COORD_W    = 12;

   localparam logic [COORD_W-1:0] COL_X0 [NUM_COLS] = '{12'd515, 12'd621, 12'd728};
   localparam logic [COORD_W-1:0] ROW_Y0 [NUM_ROWS] = '{12'd174, 12'd254, 12'd334, 12'd414};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SHOW  = 2'd2
   } hl_state_t;

   // Keys are numbered row-major over the 3-column grid; only codes 0..11 reach these.
   function automatic logic [COORD_W-1:0] key_x0(input logic [3:0] k);
      logic [1:0] c;
      c = 2'(k % 4'd3);
      return COL_X0[c];
   endfunction

   function automatic logic [COORD_W-1:0] key_y0(input logic [3:0] k);
      logic [1:0] r;
      r = 2'(k / 4'd3);
      return ROW_Y0[r];
   endfunction

endpackage

// File: rtl/video_xy_counter.sv
// Pixel/line position tracker: x counts de-high pixels already seen in the line,
// y counts de falling edges since the last vsync falling edge.
module video_xy_counter
   import keypad_osd_pkg::*;
(
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               i_vs,
   input  logic               i_de,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               frame_start
);

   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   logic vs_d;
   logic de_d;

   assign frame_start = vs_d & ~i_vs;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d <= 1'b0;
         de_d <= 1'b0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_d <= i_vs;
         de_d <= i_de;
         if (!i_de) begin
            x <= '0;
         end else if (x != COORD_MAX) begin
            x <= x + 1'b1;
         end
         // Frame start wins over a coincident de falling edge.
         if (frame_start) begin
            y <= '0;
         end else if (de_d && !i_de && (y != COORD_MAX)) begin
            y <= y + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_highlight_overlay.sv
// Draws a hollow box around the last pressed keypad cell for HOLD_FRAMES frames;
// highlight changes are applied only at vsync falling edges so no frame is torn.
module key_highlight_overlay
   import keypad_osd_pkg::*;
#(
   parameter int          HOLD_FRAMES = 30,
   parameter logic [23:0] BOX_COLOR   = 24'h00ff00,
   parameter int          BORDER      = 2
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic        i_de,
   input  logic [23:0] i_data,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic [23:0] o_data,
   output logic        o_active,
   output hl_state_t   dbg_state
);

   localparam logic [COORD_W-1:0] OFS_LO = COORD_W'(BOX_MARGIN);
   localparam logic [COORD_W-1:0] OFS_HX = COORD_W'(DIGIT_W + BOX_MARGIN - 1);
   localparam logic [COORD_W-1:0] OFS_HY = COORD_W'(DIGIT_H + BOX_MARGIN - 1);
   localparam logic [COORD_W-1:0] BRD    = COORD_W'(BORDER);
   localparam logic [7:0]         HOLD   = 8'(HOLD_FRAMES);

   logic [COORD_W-1:0] x, y;
   logic               frame_start;

   hl_state_t  state, state_nx;
   logic       pend_flag;
   logic [3:0] pend_code;
   logic [3:0] show_code, show_nx;
   logic [7:0] hold_cnt, hold_nx;
   logic       consume;
   logic       key_ok;

   logic [COORD_W-1:0] x0, y0, bx_lo, bx_hi, by_lo, by_hi;
   logic               in_box, in_inner, paint;

   video_xy_counter u_xy (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .i_vs        (i_vs),
      .i_de        (i_de),
      .x           (x),
      .y           (y),
      .frame_start (frame_start)
   );

   // key_valid is a one-cycle strobe with no backpressure: key_code is sampled
   // only in that cycle, and out-of-range codes are dropped without side effects.
   assign key_ok    = key_valid && (key_code < 4'(NUM_KEYS));
   assign dbg_state = state;

   always_comb begin
      state_nx = state;
      show_nx  = show_code;
      hold_nx  = hold_cnt;
      consume  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend_flag) state_nx = ST_ARMED;
         end
         ST_ARMED: begin
            if (frame_start) begin
               state_nx = ST_SHOW;
               show_nx  = pend_code;
               hold_nx  = HOLD;
               consume  = 1'b1;
            end
         end
         ST_SHOW: begin
            if (frame_start) begin
               if (pend_flag) begin
                  show_nx = pend_code;
                  hold_nx = HOLD;
                  consume = 1'b1;
               end else if (hold_cnt <= 8'd1) begin
                  hold_nx  = '0;
                  state_nx = ST_IDLE;
               end else begin
                  hold_nx = hold_cnt - 8'd1;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      x0       = key_x0(show_code);
      y0       = key_y0(show_code);
      bx_lo    = x0 - OFS_LO;
      bx_hi    = x0 + OFS_HX;
      by_lo    = y0 - OFS_LO;
      by_hi    = y0 + OFS_HY;
      in_box   = (x >= bx_lo) && (x <= bx_hi) && (y >= by_lo) && (y <= by_hi);
      in_inner = (x >= bx_lo + BRD) && (x <= bx_hi - BRD) &&
                 (y >= by_lo + BRD) && (y <= by_hi - BRD);
      paint    = (state == ST_SHOW) && i_de && in_box && !in_inner;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pend_flag <= 1'b0;
         pend_code <= '0;
         show_code <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nx;
         show_code <= show_nx;
         hold_cnt  <= hold_nx;
         // A fresh key always lands in pending, even when the old one is consumed now.
         if (key_ok) begin
            pend_flag <= 1'b1;
            pend_code <= key_code;
         end else if (consume) begin
            pend_flag <= 1'b0;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         o_hs     <= 1'b0;
         o_vs     <= 1'b0;
         o_de     <= 1'b0;
         o_data   <= '0;
         o_active <= 1'b0;
      end else begin
         o_hs     <= i_hs;
         o_vs     <= i_vs;
         o_de     <= i_de;
         o_data   <= paint ? BOX_COLOR : i_data;
         o_active <= (state_nx == ST_SHOW);
      end
   end

endmodule

// File: tb/tb_key_highlight_overlay.sv
// Directed frame-level bench for key_highlight_overlay with a cycle-tagged
// expected-output queue checked by an independent monitor.
module tb_key_highlight_overlay;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic        i_hs, i_vs, i_de;
   logic [23:0] i_data;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        o_hs, o_vs, o_de, o_active;
   logic [23:0] o_data;
   logic [1:0]  dbg_state;

   key_highlight_overlay #(
      .HOLD_FRAMES (3),
      .BOX_COLOR   (24'h00ff00),
      .BORDER      (2)
   ) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .i_hs      (i_hs),
      .i_vs      (i_vs),
      .i_de      (i_de),
      .i_data    (i_data),
      .key_valid (key_valid),
      .key_code  (key_code),
      .o_hs      (o_hs),
      .o_vs      (o_vs),
      .o_de      (o_de),
      .o_data    (o_data),
      .o_active  (o_active),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [27:0] exp_q[$];
   int          due_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        cur_active = 1'b0;

   // Hand-computed box corners (x = X0-8, y = Y0-8); box is 32 x 48.
   int col_box [3] = '{507, 613, 720};
   int row_box [4] = '{166, 246, 326, 406};
   int probe_ofs [8] = '{-9, -8, -7, -6, 16, 37, 39, 40};

   function automatic logic [23:0] exp_pix(input int key, input int x, input int y,
                                           input logic [23:0] d);
      int bx, by;
      if (key < 0) return d;
      bx = col_box[key % 3];
      by = row_box[key / 3];
      if (x >= bx && x <= bx + 31 && y >= by && y <= by + 47 &&
          !(x >= bx + 2 && x <= bx + 29 && y >= by + 2 && y <= by + 45))
         return 24'h00ff00;
      return d;
   endfunction

   function automatic bit is_long(input int y, input int r);
      for (int i = 0; i < 8; i++) if (y == r + probe_ofs[i]) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic hs, input logic vs, input logic de,
                        input logic [23:0] d, input logic kv, input logic [3:0] kc,
                        input logic [23:0] expd);
      @(negedge pclk);
      i_hs      = hs;
      i_vs      = vs;
      i_de      = de;
      i_data    = d;
      key_valid = kv;
      key_code  = kc;
      exp_q.push_back({hs, vs, de, cur_active, expd});
      due_q.push_back(cyc + 1);
   endtask

   task automatic vsync_start(input logic act, input int kstart);
      logic [23:0] d;
      repeat (2) begin
         d = 24'($urandom);
         drive(1'b0, 1'b1, 1'b0, d, 1'b0, 4'd0, d);
      end
      cur_active = act;
      d = 24'($urandom);
      drive(1'b0, 1'b0, 1'b0, d, (kstart >= 0), 4'(kstart), d);
      d = 24'($urandom);
      drive(1'b0, 1'b0, 1'b0, d, 1'b0, 4'd0, d);
   endtask

   task automatic frame_body(input int ra, input int rb, input int lw, input int nlines,
                             input int show_key, input int ka, input int kb);
      logic [23:0] d;
      logic        kv;
      logic [3:0]  kc;
      for (int y = 0; y < nlines; y++) begin
         if (is_long(y, ra) || is_long(y, rb)) begin
            for (int x = 0; x < lw; x++) begin
               d = 24'($urandom);
               drive(1'b0, 1'b0, 1'b1, d, 1'b0, 4'd0, exp_pix(show_key, x, y, d));
            end
         end else begin
            d = 24'($urandom);
            drive(1'b0, 1'b0, 1'b1, d, 1'b0, 4'd0, exp_pix(show_key, 0, y, d));
         end
         kv = 1'b0;
         kc = 4'd0;
         if (y == 1 && ka >= 0) begin kv = 1'b1; kc = 4'(ka); end
         if (y == 2 && kb >= 0) begin kv = 1'b1; kc = 4'(kb); end
         d = 24'($urandom);
         drive(1'b1, 1'b0, 1'b0, d, kv, kc, d);
      end
   endtask

   task automatic check_zero(input string name);
      logic [29:0] got;
      got = {o_hs, o_vs, o_de, o_active, o_data, dbg_state};
      n_vec++;
      if (got !== 30'd0) begin
         n_err++;
         $display("FAIL %s got=%h want=0", name, got);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge pclk) begin : monitor
      logic [27:0] want, got;
      int          due;
      if (exp_q.size() != 0 && due_q[0] <= cyc) begin
         want = exp_q.pop_front();
         due  = due_q.pop_front();
         got  = {o_hs, o_vs, o_de, o_active, o_data};
         n_vec++;
         if (due != cyc || got !== want) begin
            n_err++;
            $display("FAIL out_stream cyc=%0d due=%0d got{hs,vs,de,act,data}=%h want=%h",
                     cyc, due, got, want);
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam int NOL = -1000;

   initial begin
      logic [23:0] d;
      rst_n = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
      i_data = 24'h123456; key_valid = 1'b0; key_code = 4'd0;
      repeat (3) @(negedge pclk);
      check_zero("reset_state");
      rst_n = 1'b1;

      // key 4 pressed, then shown for HOLD frames
      vsync_start(1'b0, -1); frame_body(NOL, NOL, 0, 4, -1, 4, -1);
      vsync_start(1'b1, -1); frame_body(254, 254, 650, 295, 4, -1, -1);
      vsync_start(1'b1, -1); frame_body(NOL, NOL, 0, 4, 4, -1, -1);
      vsync_start(1'b1, -1); frame_body(NOL, NOL, 0, 4, 4, -1, -1);
      // hold expires; invalid key 13 is ignored
      vsync_start(1'b0, -1); frame_body(NOL, NOL, 0, 4, -1, 13, -1);
      vsync_start(1'b0, -1); frame_body(254, 254, 650, 295, -1, -1, -1);
      // key 0: exactly three highlighted frames, then idle
      vsync_start(1'b0, -1); frame_body(NOL, NOL, 0, 4, -1, 0, -1);
      repeat (3) begin
         vsync_start(1'b1, -1); frame_body(174, 174, 545, 215, 0, -1, -1);
      end
      vsync_start(1'b0, -1); frame_body(174, 174, 545, 215, -1, -1, -1);
      // key 2 overwritten by key 9 within one frame
      vsync_start(1'b0, -1); frame_body(NOL, NOL, 0, 4, -1, 2, 9);
      vsync_start(1'b1, -1); frame_body(174, 414, 760, 455, 9, -1, -1);
      vsync_start(1'b1, -1); frame_body(NOL, NOL, 0, 4, 9, -1, -1);
      vsync_start(1'b1, -1); frame_body(NOL, NOL, 0, 4, 9, -1, -1);
      vsync_start(1'b0, -1); frame_body(NOL, NOL, 0, 4, -1, -1, -1);
      // key in the frame-start cycle appears one frame later
      vsync_start(1'b0, 0); frame_body(174, 174, 545, 215, -1, -1, -1);
      vsync_start(1'b1, -1); frame_body(174, 174, 545, 215, 0, -1, -1);
      // reset mid-line while the box top border is being painted
      vsync_start(1'b1, -1); frame_body(NOL, NOL, 0, 166, 0, -1, -1);
      for (int x = 0; x <= 510; x++) begin
         d = 24'($urandom);
         drive(1'b0, 1'b0, 1'b1, d, 1'b0, 4'd0, exp_pix(0, x, 166, d));
      end
      @(posedge pclk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      due_q.delete();
      cur_active = 1'b0;
      #1 check_zero("mid_line_reset");
      #1 rst_n = 1'b1;
      for (int x = 511; x < 545; x++) begin
         d = 24'($urandom);
         drive(1'b0, 1'b0, 1'b1, d, 1'b0, 4'd0, d);
      end
      d = 24'($urandom);
      drive(1'b1, 1'b0, 1'b0, d, 1'b0, 4'd0, d);
      frame_body(NOL, NOL, 0, 3, -1, -1, -1);
      // no highlight after reset without a new key
      vsync_start(1'b0, -1); frame_body(174, 174, 545, 215, -1, -1, -1);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge pclk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
